// File: rtl/nmr_vote_sm.sv
// N-modular-redundancy voter: collects one word per core, compares them once all are in
// (or a timeout expires), and raises a level interrupt holding the vote result.
module nmr_vote_sm #(
  parameter int WIDTH          = 32,
  parameter int N_CORES        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CORES*WIDTH-1:0]   data_in,
  input  logic [N_CORES-1:0]         data_set,
  input  logic                       irq_ack,
  output logic                       is_match,
  output logic [WIDTH-1:0]           voted_data,
  output logic [N_CORES-1:0]         fault_mask,
  output logic                       no_majority,
  output logic                       timeout,
  output logic                       interrupt_prompt,
  output logic [15:0]                mismatch_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter reads TIMEOUT_CYCLES-2 on the edge that advances it to TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]         HALF       = 4'(N_CORES / 2);
  localparam logic [N_CORES-1:0] ALL_LOADED = '1;

  typedef enum logic [1:0] {IDLE, COMPARE, IRQ} state_t;

  state_t             state;
  logic [WIDTH-1:0]   core_word [N_CORES];
  logic [N_CORES-1:0] loaded;
  logic [N_CORES-1:0] loaded_next;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [15:0]        count_inc;

  logic               cmp_match;
  logic               cmp_has_maj;
  logic [WIDTH-1:0]   cmp_voted;
  logic [N_CORES-1:0] cmp_fault;
  logic [3:0]         agree;

  assign loaded_next = loaded | data_set;
  assign count_inc   = (mismatch_count == 16'hFFFF) ? mismatch_count : mismatch_count + 16'd1;

  // A majority word is unique, so the first register reaching it defines the vote.
  always_comb begin
    cmp_match   = 1'b1;
    cmp_has_maj = 1'b0;
    cmp_voted   = '0;
    cmp_fault   = '1;
    agree       = '0;
    for (int i = 0; i < N_CORES; i++) begin
      agree = '0;
      for (int j = 0; j < N_CORES; j++) begin
        if (core_word[j] == core_word[i]) agree = agree + 4'd1;
      end
      if (core_word[i] != core_word[0]) cmp_match = 1'b0;
      if ((agree > HALF) && !cmp_has_maj) begin
        cmp_has_maj = 1'b1;
        cmp_voted   = core_word[i];
      end
    end
    for (int i = 0; i < N_CORES; i++) begin
      cmp_fault[i] = !cmp_has_maj || (core_word[i] != cmp_voted);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      loaded           <= '0;
      tmo_cnt          <= '0;
      is_match         <= 1'b0;
      voted_data       <= '0;
      fault_mask       <= '0;
      no_majority      <= 1'b0;
      timeout          <= 1'b0;
      interrupt_prompt <= 1'b0;
      mismatch_count   <= '0;
      for (int i = 0; i < N_CORES; i++) core_word[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < N_CORES; i++) begin
            if (data_set[i] && !loaded[i]) core_word[i] <= data_in[i*WIDTH +: WIDTH];
          end
          loaded <= loaded_next;
          if (loaded == ALL_LOADED) begin
            state <= COMPARE;
          end else if ((loaded != '0) && (loaded_next != ALL_LOADED)) begin
            if (tmo_cnt == CNT_LAST) begin
              state            <= IRQ;
              interrupt_prompt <= 1'b1;
              timeout          <= 1'b1;
              is_match         <= 1'b0;
              no_majority      <= 1'b1;
              voted_data       <= '0;
              fault_mask       <= ~loaded_next;
              mismatch_count   <= count_inc;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        COMPARE: begin
          state            <= IRQ;
          interrupt_prompt <= 1'b1;
          timeout          <= 1'b0;
          is_match         <= cmp_match;
          no_majority      <= !cmp_has_maj;
          voted_data       <= cmp_voted;
          fault_mask       <= cmp_fault;
          if (!cmp_match) mismatch_count <= count_inc;
        end
        IRQ: begin
          if (irq_ack) begin
            state            <= IDLE;
            interrupt_prompt <= 1'b0;
            loaded           <= '0;
            tmo_cnt          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_vote_sm.sv
// Directed bench for nmr_vote_sm: a 3-core instance with a short timeout and a 2-core instance.
module tb_nmr_vote_sm;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [95:0] data_in;
  logic [2:0]  data_set;
  logic        irq_ack;
  logic        is_match, no_majority, timeout, interrupt_prompt;
  logic [31:0] voted_data;
  logic [2:0]  fault_mask;
  logic [15:0] mismatch_count;

  logic [63:0] data_in2;
  logic [1:0]  data_set2;
  logic        irq_ack2;
  logic        is_match2, no_majority2, timeout2, interrupt_prompt2;
  logic [31:0] voted_data2;
  logic [1:0]  fault_mask2;
  logic [15:0] mismatch_count2;

  nmr_vote_sm #(.WIDTH(32), .N_CORES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_set(data_set), .irq_ack(irq_ack),
    .is_match(is_match), .voted_data(voted_data), .fault_mask(fault_mask),
    .no_majority(no_majority), .timeout(timeout), .interrupt_prompt(interrupt_prompt),
    .mismatch_count(mismatch_count)
  );

  nmr_vote_sm #(.WIDTH(32), .N_CORES(2), .TIMEOUT_CYCLES(16)) dut2 (
    .clk(clk), .reset(reset), .data_in(data_in2), .data_set(data_set2), .irq_ack(irq_ack2),
    .is_match(is_match2), .voted_data(voted_data2), .fault_mask(fault_mask2),
    .no_majority(no_majority2), .timeout(timeout2), .interrupt_prompt(interrupt_prompt2),
    .mismatch_count(mismatch_count2)
  );

  typedef struct {
    logic [31:0] w0, w1, w2;
    logic        exp_match;
    logic [31:0] exp_vote;
    logic [2:0]  exp_fault;
    logic        exp_nomaj;
  } vec_t;

  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] count_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a falling edge; the next rising edge samples the strobe.
  task automatic load(input logic [2:0] set, input logic [95:0] din);
    data_in  = din;
    data_set = set;
    @(negedge clk);
    data_set = 3'b000;
  endtask

  task automatic finish_round(input string tag);
    chk({tag, "/prompt_e0"}, interrupt_prompt, 0);
    @(negedge clk);
    chk({tag, "/prompt_cmp"}, interrupt_prompt, 0);
    @(negedge clk);
    chk({tag, "/prompt_irq"}, interrupt_prompt, 1);
  endtask

  task automatic check_result(input string tag, input logic m, input logic [31:0] v,
                              input logic [2:0] f, input logic nm, input logic t);
    chk({tag, "/is_match"}, is_match, m);
    chk({tag, "/voted"}, voted_data, v);
    chk({tag, "/fault"}, fault_mask, f);
    chk({tag, "/no_maj"}, no_majority, nm);
    chk({tag, "/timeout"}, timeout, t);
    chk({tag, "/count"}, mismatch_count, count_exp);
    $display("round %s: match=%0b vote=%h fault=%b nomaj=%0b tmo=%0b count=%h",
             tag, is_match, voted_data, fault_mask, no_majority, timeout, mismatch_count);
  endtask

  task automatic ack(input string tag, input logic [2:0] set);
    irq_ack  = 1'b1;
    data_set = set;
    @(negedge clk);
    irq_ack  = 1'b0;
    data_set = 3'b000;
    chk({tag, "/prompt_ack"}, interrupt_prompt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 3'b000, 1'b0};
    vecs[1] = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 32'h00000001, 3'b100, 1'b0};
    vecs[2] = '{32'h00000007, 32'h00000009, 32'h00000007, 1'b0, 32'h00000007, 3'b010, 1'b0};
    vecs[3] = '{32'h00000003, 32'h00000005, 32'h00000005, 1'b0, 32'h00000005, 3'b001, 1'b0};
    vecs[4] = '{32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 32'h00000000, 3'b111, 1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 3'b010, 1'b0};

    reset = 1'b0; data_in = '0; data_set = '0; irq_ack = 1'b0;
    data_in2 = '0; data_set2 = '0; irq_ack2 = 1'b0; count_exp = '0;

    #2;
    chk("reset/prompt", interrupt_prompt, 0);
    chk("reset/is_match", is_match, 0);
    chk("reset/voted", voted_data, 0);
    chk("reset/fault", fault_mask, 0);
    chk("reset/no_maj", no_majority, 0);
    chk("reset/timeout", timeout, 0);
    chk("reset/count", mismatch_count, 0);
    chk("reset/prompt2", interrupt_prompt2, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table: all three cores load in one cycle; the first one right after reset release.
    for (int v = 0; v < 7; v++) begin
      load(3'b111, {vecs[v].w2, vecs[v].w1, vecs[v].w0});
      finish_round($sformatf("vec%0d", v));
      if (!vecs[v].exp_match) count_exp = count_exp + 16'd1;
      check_result($sformatf("vec%0d", v), vecs[v].exp_match, vecs[v].exp_vote,
                   vecs[v].exp_fault, vecs[v].exp_nomaj, 1'b0);
      ack($sformatf("vec%0d", v), 3'b000);
    end

    // Loads on separate cycles, core 1 disagrees.
    load(3'b001, {64'h0, 32'h12345678});
    load(3'b010, {32'h0, 32'h12345679, 32'h0});
    load(3'b100, {32'h12345678, 64'h0});
    finish_round("split");
    count_exp = count_exp + 16'd1;
    check_result("split", 1'b0, 32'h12345678, 3'b010, 1'b0, 1'b0);
    ack("split", 3'b000);

    // A second strobe on core 0 must not overwrite its first word.
    load(3'b001, {64'h0, 32'h11111111});
    load(3'b001, {64'h0, 32'h22222222});
    load(3'b110, {32'h11111111, 32'h11111111, 32'h0});
    finish_round("dup");
    check_result("dup", 1'b1, 32'h11111111, 3'b000, 1'b0, 1'b0);
    ack("dup", 3'b000);

    // Timeout: cores 0 and 1 only; IRQ on the 7th edge after the first load.
    load(3'b001, {64'h0, 32'hAAAA0000});
    load(3'b010, {32'h0, 32'hAAAA0000, 32'h0});
    repeat (5) @(negedge clk);
    chk("tmo/prompt_early", interrupt_prompt, 0);
    @(negedge clk);
    chk("tmo/prompt_irq", interrupt_prompt, 1);
    count_exp = count_exp + 16'd1;
    check_result("tmo", 1'b0, 32'h0, 3'b100, 1'b1, 1'b1);

    // Strobes coincident with the acknowledge are dropped; next round starts empty.
    data_in = {32'hCCCCCCCC, 32'hCCCCCCCC, 32'hCCCCCCCC};
    ack("ackset", 3'b111);
    repeat (3) @(negedge clk);
    chk("ackset/prompt_idle", interrupt_prompt, 0);
    load(3'b111, {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hBBBBBBBB});
    finish_round("after_ack");
    count_exp = count_exp + 16'd1;
    check_result("after_ack", 1'b0, 32'hBBBBBBBB, 3'b100, 1'b0, 1'b0);
    ack("after_ack", 3'b000);

    // Two-core instance: any mismatch has no majority.
    data_in2  = {32'd2, 32'd1};
    data_set2 = 2'b11;
    @(negedge clk);
    data_set2 = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("n2/prompt", interrupt_prompt2, 1);
    chk("n2/is_match", is_match2, 0);
    chk("n2/no_maj", no_majority2, 1);
    chk("n2/voted", voted_data2, 0);
    chk("n2/fault", fault_mask2, 2'b11);
    chk("n2/count", mismatch_count2, 1);
    $display("round n2: match=%0b vote=%h fault=%b nomaj=%0b", is_match2, voted_data2,
             fault_mask2, no_majority2);
    irq_ack2 = 1'b1;
    @(negedge clk);
    irq_ack2 = 1'b0;
    chk("n2/prompt_ack", interrupt_prompt2, 0);

    // Reset while in IRQ clears everything before the next clock edge.
    load(3'b111, {32'd3, 32'd2, 32'd1});
    finish_round("rst_irq");
    chk("rst_irq/fault_pre", fault_mask, 3'b111);
    #2 reset = 1'b0;
    #1;
    chk("rst_irq/prompt", interrupt_prompt, 0);
    chk("rst_irq/fault", fault_mask, 0);
    chk("rst_irq/no_maj", no_majority, 0);
    chk("rst_irq/count", mismatch_count, 0);
    $display("round rst_irq: prompt=%0b fault=%b count=%h", interrupt_prompt, fault_mask,
             mismatch_count);
    @(negedge clk);
    reset = 1'b1;

    // Saturation: preload the counter just below its limit.
    force dut.mismatch_count = 16'hFFFE;
    #1;
    release dut.mismatch_count;
    @(negedge clk);
    chk("sat/preload", mismatch_count, 16'hFFFE);
    count_exp = 16'hFFFF;
    for (int r = 0; r < 2; r++) begin
      load(3'b111, {32'd3, 32'd2, 32'd1});
      finish_round($sformatf("sat%0d", r));
      check_result($sformatf("sat%0d", r), 1'b0, 32'h0, 3'b111, 1'b1, 1'b0);
      ack($sformatf("sat%0d", r), 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmr_vote_sm.md
NMR_VOTE_SM -- requirements
Module: nmr_vote_sm

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each core's data word.
REQ-002 SHALL have parameter N_CORES, default 3, legal 2..5: number of redundant cores compared.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, legal >=2: cycles allowed from first load to last load.
REQ-004 Ports, in order:
 clk  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-low reset.
 data_in  in  N_CORES*WIDTH  flattened core words; slice i = bits [i*WIDTH +: WIDTH].
 data_set  in  N_CORES  per-core load strobe; bit i high for one clk captures slice i.
 irq_ack  in  1  processor acknowledge; re-arms the block.
 is_match  out  1  all captured words equal.
 voted_data  out  WIDTH  majority word; 0 when no majority.
 fault_mask  out  N_CORES  bit i set = core i disagrees with voted_data or never loaded.
 no_majority  out  1  no word held by more than N_CORES/2 cores.
 timeout  out  1  last compare ended by timeout.
 interrupt_prompt  out  1  level interrupt to processor.
 mismatch_count  out  16  saturating count of failed rounds.

Function
REQ-005 SHALL implement states IDLE, COMPARE, IRQ.
REQ-006 In IDLE, a data_set[i] pulse with loaded[i]=0 SHALL capture slice i into internal register i and set loaded[i]; a pulse with loaded[i]=1 SHALL be ignored (first write wins).
REQ-007 Simultaneous data_set bits SHALL each be captured in the same cycle.
REQ-008 IDLE -> COMPARE SHALL occur on the edge after loaded is all ones.
REQ-009 A timeout counter SHALL start at 0 on the edge that sets the first loaded bit and increment each cycle while in IDLE with loaded non-zero and not all ones.
REQ-010 When the counter reaches TIMEOUT_CYCLES-1 with loaded not all ones, the block SHALL enter IRQ directly, set timeout=1, fault_mask=~loaded, is_match=0, no_majority=1, voted_data=0.
REQ-011 COMPARE SHALL last exactly one cycle and register all result outputs on its exit edge, then enter IRQ.
REQ-012 is_match SHALL be 1 iff all N_CORES captured words are bitwise equal.
REQ-013 voted_data SHALL be the word equal in more than N_CORES/2 captured registers (integer division); fault_mask bit i SHALL be set iff register i differs from it.
REQ-014 If no such word exists (always the case for N_CORES=2 on mismatch), no_majority=1, voted_data=0, fault_mask all ones.
REQ-015 interrupt_prompt SHALL be 1 exactly while in IRQ; it rises two clk edges after the edge sampling the final data_set.
REQ-016 In IRQ, irq_ack=1 SHALL return to IDLE on that edge, clear loaded and the timeout counter; result outputs SHALL hold until the next round's results are registered.
REQ-017 data_set in COMPARE or IRQ SHALL be ignored, including when coincident with irq_ack.
REQ-018 irq_ack outside IRQ SHALL be ignored.
REQ-019 mismatch_count SHALL increment by 1 on each registered result with is_match=0 (including timeout) and saturate at 0xFFFF.
REQ-020 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, loaded=0, counter=0, all outputs 0, mismatch_count=0, asynchronously to clk.
REQ-022 reset asserted mid-round SHALL discard captured words; the first round after release starts from empty.
REQ-023 After reset deassertion, data_set SHALL be honoured from the first rising clk edge.

Verification
REQ-024 N=3: load A5A5A5A5 on all three in one cycle -> interrupt_prompt high 2 edges later, is_match=1, voted_data=A5A5A5A5, fault_mask=000, count=0.
REQ-025 N=3: cores 0,2 load 12345678, core 1 loads 12345679 on separate cycles -> is_match=0, voted_data=12345678, fault_mask=010, no_majority=0, count=1.
REQ-026 N=2: load 1 and 2 -> is_match=0, no_majority=1, voted_data=0, fault_mask=11; irq_ack -> IDLE, interrupt_prompt=0 next cycle.
REQ-027 N=3, TIMEOUT_CYCLES=8: load cores 0,1 only -> 7 cycles after first load enter IRQ, timeout=1, fault_mask=100.
REQ-028 Duplicate data_set[0] with new value before others load -> first value used; data_set during IRQ with irq_ack -> ignored, next round starts empty.
REQ-029 Assert reset during IRQ -> interrupt_prompt and all outputs 0 before next clk edge; force 0x10000 failures (or preload) -> mismatch_count holds 0xFFFF.
